// File: rtl/out_mem_streamer.sv
// Raster-order reader for the output image BRAM: streams w*h pixels as a valid/ready
// byte stream with row/frame markers, plus running checksum and pixel count.
module out_mem_streamer #(
  parameter int AW     = 12,
  parameter int FIFO_D = 2
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   i_out_w,
  input  logic [15:0]   i_out_h,
  output logic          busy,
  output logic          done,
  output logic          o_err_size,
  output logic [AW-1:0] mem_raddr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last_row,
  output logic          m_last_frame,
  output logic [31:0]   o_checksum,
  output logic [31:0]   o_pix_count
);

  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = PW + 2;
  localparam logic [31:0] MAX_PIX = 32'd1 << AW;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [15:0]   w_reg, h_reg, x_reg, y_reg;
  logic [AW:0]   total_reg, rd_cnt_reg;
  logic [AW-1:0] raddr_reg;
  logic          err_reg;
  logic          inflight_reg, inflight_row_reg, inflight_frame_reg;
  logic [PW-1:0] wr_idx_reg, rd_idx_reg;
  logic [PW:0]   count_reg;
  logic [31:0]   checksum_reg, pix_count_reg;

  logic [31:0]          product;
  logic                 size_bad, accept, fire, issue, x_last, issue_last_frame;
  logic [CW-1:0]        used;
  logic [FIFO_D*10-1:0] fifo_flat;
  logic [9:0]           head;

  assign accept           = (state_reg == S_IDLE) && start;
  assign product          = 32'(w_reg) * 32'(h_reg);
  assign size_bad         = (product == 32'd0) || (product > MAX_PIX);
  assign m_valid          = (count_reg != '0);
  assign fire             = m_valid && m_ready;
  // Credit counts the beat leaving this cycle so a full pipe still sustains 1 pixel/cycle.
  assign used             = CW'(count_reg) + CW'(inflight_reg) - CW'(fire);
  assign issue            = (state_reg == S_RUN) && (rd_cnt_reg != total_reg) && (used < CW'(FIFO_D));
  assign x_last           = (x_reg == w_reg - 16'd1);
  assign issue_last_frame = x_last && (y_reg == h_reg - 16'd1);
  assign mem_raddr        = issue ? rd_cnt_reg[AW-1:0] : raddr_reg;

  assign busy         = (state_reg == S_CHECK) || (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign done         = (state_reg == S_DONE);
  assign o_err_size   = err_reg;
  assign o_checksum   = checksum_reg;
  assign o_pix_count  = pix_count_reg;
  assign head         = fifo_flat[int'(rd_idx_reg)*10 +: 10];
  assign m_data       = head[7:0];
  assign m_last_row   = head[8];
  assign m_last_frame = head[9];

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_CHECK;
      // Size errors pass through DRAIN so done lands a fixed two cycles after start.
      S_CHECK: state_next = size_bad ? S_DRAIN : S_RUN;
      S_RUN:   if (issue && issue_last_frame) state_next = S_DRAIN;
      S_DRAIN: if (err_reg || (fire && m_last_frame)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      w_reg              <= '0;
      h_reg              <= '0;
      x_reg              <= '0;
      y_reg              <= '0;
      total_reg          <= '0;
      rd_cnt_reg         <= '0;
      raddr_reg          <= '0;
      err_reg            <= 1'b0;
      inflight_reg       <= 1'b0;
      inflight_row_reg   <= 1'b0;
      inflight_frame_reg <= 1'b0;
      checksum_reg       <= '0;
      pix_count_reg      <= '0;
    end else begin
      if (accept) begin
        w_reg   <= i_out_w;
        h_reg   <= i_out_h;
        err_reg <= 1'b0;
      end
      if (state_reg == S_CHECK) begin
        err_reg    <= size_bad;
        total_reg  <= size_bad ? '0 : product[AW:0];
        rd_cnt_reg <= '0;
        x_reg      <= '0;
        y_reg      <= '0;
      end
      if (issue) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
        raddr_reg  <= rd_cnt_reg[AW-1:0];
        if (x_last) begin
          x_reg <= '0;
          y_reg <= y_reg + 16'd1;
        end else begin
          x_reg <= x_reg + 16'd1;
        end
      end
      inflight_reg       <= issue;
      inflight_row_reg   <= x_last;
      inflight_frame_reg <= issue_last_frame;
      if (accept) begin
        checksum_reg  <= '0;
        pix_count_reg <= '0;
      end else if (fire) begin
        checksum_reg  <= checksum_reg + 32'(m_data);
        pix_count_reg <= pix_count_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (inflight_reg) wr_idx_reg <= wr_idx_reg + 1'b1;
      if (fire)         rd_idx_reg <= rd_idx_reg + 1'b1;
      count_reg <= count_reg + (PW+1)'(inflight_reg) - (PW+1)'(fire);
    end
  end

  generate
    for (genvar gi = 0; gi < FIFO_D; gi++) begin : g_fifo
      logic [9:0] entry_reg;
      always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n)
          entry_reg <= '0;
        else if (inflight_reg && (wr_idx_reg == PW'(gi)))
          entry_reg <= {inflight_frame_reg, inflight_row_reg, mem_rdata};
      end
      assign fifo_flat[gi*10 +: 10] = entry_reg;
    end
  endgenerate

endmodule

// File: tb/tb_out_mem_streamer.sv
// Directed bench for out_mem_streamer: BRAM model mem[a]=a[7:0], in-order beat scoreboard,
// stall-hold checks, size errors, ignored starts and mid-frame reset.
module tb_out_mem_streamer;
  localparam int AW     = 12;
  localparam int FIFO_D = 2;

  logic          clk_50 = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   i_out_w, i_out_h;
  logic          busy, done, o_err_size;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_rdata = 8'h00;
  logic [7:0]    m_data;
  logic          m_valid, m_ready, m_last_row, m_last_frame;
  logic [31:0]   o_checksum, o_pix_count;

  logic [7:0] bram [1<<AW];

  int checks = 0;
  int errors = 0;
  int exp_idx = 0;
  int frame_w = 1;
  int frame_h = 1;
  bit mon_en = 1'b0;
  bit stall_prev = 1'b0;
  logic [9:0] prev_word = '0;
  logic [9:0] exp_word;

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) mem_rdata <= bram[mem_raddr];

  out_mem_streamer #(.AW(AW), .FIFO_D(FIFO_D)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .start(start), .i_out_w(i_out_w), .i_out_h(i_out_h),
    .busy(busy), .done(done), .o_err_size(o_err_size), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last_row(m_last_row), .m_last_frame(m_last_frame),
    .o_checksum(o_checksum), .o_pix_count(o_pix_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Beat scoreboard and stall-hold monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk_50);
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else if (mon_en) begin
      if (stall_prev)
        check("hold", {21'd0, m_valid, m_last_frame, m_last_row, m_data}, {21'd0, 1'b1, prev_word});
      if (m_valid && m_ready) begin
        exp_word = {(exp_idx == frame_w*frame_h-1), ((exp_idx % frame_w) == frame_w-1), 8'(exp_idx)};
        check("beat", {22'd0, m_last_frame, m_last_row, m_data}, {22'd0, exp_word});
        exp_idx++;
      end
      stall_prev = m_valid && !m_ready;
      prev_word  = {m_last_frame, m_last_row, m_data};
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_flags"}, {26'd0, busy, done, o_err_size, m_valid, m_last_row, m_last_frame}, 32'd0);
    check({tag, "_raddr"}, 32'(mem_raddr), 32'd0);
    check({tag, "_data"}, 32'(m_data), 32'd0);
    check({tag, "_sum"}, o_checksum, 32'd0);
    check({tag, "_cnt"}, o_pix_count, 32'd0);
  endtask

  // mode 0: ready high; 1: ready random; 2: ready low for 100 cycles after first valid.
  task automatic run_frame(input string name, input int w, input int h, input int mode,
                           input int exp_done, input bit exp_err, input bit poke);
    int n, cyc, first_valid, limit;
    logic [31:0]   sum;
    logic [AW-1:0] raddr_before;
    n = exp_err ? 0 : w*h;
    sum = 32'd0;
    for (int i = 0; i < n; i++) sum += 32'(i % 256);
    frame_w = (w == 0) ? 1 : w;
    frame_h = h;
    exp_idx = 0;
    mon_en  = 1'b1;
    raddr_before = mem_raddr;
    @(negedge clk_50);
    start = 1'b1; i_out_w = 16'(w); i_out_h = 16'(h);
    @(posedge clk_50); #1;
    start = 1'b0; i_out_w = 16'hffff; i_out_h = 16'h0003;
    cyc = 0; first_valid = -1; limit = 4*n + 400;
    while (!done && cyc < limit) begin
      if (m_valid && first_valid < 0) first_valid = cyc;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = !(first_valid < 0 || cyc < first_valid + 100);
      endcase
      if (mode == 2 && first_valid >= 0 && cyc == first_valid + 99) begin
        check("stall_raddr", 32'(mem_raddr), 32'(FIFO_D - 1));
        check("stall_valid", 32'(m_valid), 32'd1);
      end
      if (poke && cyc == 5) begin
        start = 1'b1; i_out_w = 16'd2; i_out_h = 16'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk_50); #1;
      cyc++;
    end
    check("done", 32'(done), 32'd1);
    if (exp_done >= 0) check("done_cyc", 32'(cyc), 32'(exp_done));
    check("busy_at_done", 32'(busy), 32'd0);
    check("err_size", 32'(o_err_size), 32'(exp_err));
    check("beats", 32'(exp_idx), 32'(n));
    check("checksum", o_checksum, sum);
    check("pix_count", o_pix_count, 32'(n));
    if (exp_err) check("raddr_kept", 32'(mem_raddr), 32'(raddr_before));
    if (mode == 0 && !exp_err) check("first_valid", 32'(first_valid), 32'd3);
    if (poke) begin
      start = 1'b1; i_out_w = 16'd2; i_out_h = 16'd2;
    end
    @(posedge clk_50); #1;
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("sum_hold", o_checksum, sum);
    $display("frame %s w=%0d h=%0d cycles=%0d beats=%0d sum=%0h err=%0b",
             name, w, h, cyc, exp_idx, o_checksum, o_err_size);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; i_out_w = '0; i_out_h = '0;
    for (int a = 0; a < (1<<AW); a++) bram[a] = 8'(a);
    repeat (3) @(posedge clk_50);
    #1;
    check_reset("rst");
    rst_n = 1'b1;

    run_frame("4x2", 4, 2, 0, 11, 1'b0, 1'b0);
    run_frame("51x51_rand", 51, 51, 1, -1, 1'b0, 1'b0);
    run_frame("w0h5", 0, 5, 0, 2, 1'b1, 1'b0);
    run_frame("65x64", 65, 64, 0, 2, 1'b1, 1'b0);
    run_frame("64x64", 64, 64, 0, 4099, 1'b0, 1'b0);
    check("last_raddr", 32'(mem_raddr), 32'd4095);
    run_frame("4x4_poke", 4, 4, 0, 19, 1'b0, 1'b1);
    run_frame("8x8_stall", 8, 8, 2, -1, 1'b0, 1'b0);

    frame_w = 16; frame_h = 16; exp_idx = 0;
    @(negedge clk_50);
    start = 1'b1; i_out_w = 16'd16; i_out_h = 16'd16; m_ready = 1'b1;
    @(posedge clk_50); #1;
    start = 1'b0;
    repeat (20) @(posedge clk_50);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (2) @(posedge clk_50);
    #1;
    check("rst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    $display("frame 16x16 aborted by reset");

    run_frame("4x2_after_rst", 4, 2, 0, 11, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
